// File: rtl/mips_run_ctrl_pkg.sv
// Purpose: shared state encoding for the MIPS run controller and its core slots.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_run_ctrl_pkg;

  localparam int RUN_STATE_W = 3;

  typedef enum logic [RUN_STATE_W-1:0] {
    RUN_IDLE    = 3'd0,
    RUN_RST     = 3'd1,
    RUN_RUN     = 3'd2,
    RUN_DONE    = 3'd3,
    RUN_TIMEOUT = 3'd4
  } run_state_t;

endpackage

// File: rtl/mips_run_core_slot.sv
// Purpose: per-core sticky halt flag and capture of the run cycle at first halt.
// Latency: flag and finish_cycle update on the clock edge after halt is seen.
// Backpressure: none; halt is sampled every cycle while run is high.
module mips_run_core_slot #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             run,
  input  logic             halt,
  input  logic [CNT_W-1:0] cycle_cnt,
  output logic             halted,
  output logic [CNT_W-1:0] finish_cycle
);

  // Only the first halt of an enabled core in RUN is recorded; repeats are ignored.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      halted       <= 1'b0;
      finish_cycle <= '0;
    end else if (run && en && halt && !halted) begin
      halted       <= 1'b1;
      finish_cycle <= cycle_cnt;
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Purpose: run sequencer: holds cores in reset, runs them, ends in DONE or TIMEOUT.
// Latency: all outputs registered; state-derived outputs change one edge after a decision.
// Backpressure: none; start is ignored outside IDLE/DONE/TIMEOUT, abort always wins.
module mips_run_ctrl
  import mips_run_ctrl_pkg::*;
#(
  parameter int NUM_CORES  = 1,
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [NUM_CORES-1:0]       core_en,
  input  logic [NUM_CORES-1:0]       halt,
  output logic [NUM_CORES-1:0]       core_rst,
  output logic                       running,
  output logic                       done,
  output logic                       timeout,
  output logic [NUM_CORES-1:0]       halted,
  output logic [CNT_W-1:0]           cycle_cnt,
  output logic [NUM_CORES*CNT_W-1:0] finish_cycle
);

  localparam int RCW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);

  run_state_t           state;
  run_state_t           state_nxt;
  logic                 start_acc;
  logic [RCW-1:0]       rst_cnt;
  logic [NUM_CORES-1:0] en_mask;
  logic                 all_done;
  logic                 last_cycle;
  logic                 slot_run;

  // A disabled core counts as finished; a halt arriving this cycle also counts.
  assign all_done   = &(halted | (halt & en_mask) | ~en_mask);
  assign last_cycle = (cycle_cnt == CNT_W'(MAX_CYCLES - 1));
  assign slot_run   = (state == RUN_RUN) && !abort;

  // Next-state selection; abort overrides both start and any RUN exit.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    if (abort) begin
      state_nxt = RUN_IDLE;
    end else begin
      case (state)
        RUN_IDLE, RUN_DONE, RUN_TIMEOUT: begin
          if (start) begin
            state_nxt = RUN_RST;
            start_acc = 1'b1;
          end
        end
        RUN_RST: begin
          if (rst_cnt == '0) state_nxt = RUN_RUN;
        end
        RUN_RUN: begin
          if (all_done)        state_nxt = RUN_DONE;
          else if (last_cycle) state_nxt = RUN_TIMEOUT;
        end
        default: state_nxt = RUN_IDLE;
      endcase
    end
  end

  // State register, reset-hold counter, run-cycle counter and registered status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN_IDLE;
      rst_cnt   <= '0;
      cycle_cnt <= '0;
      en_mask   <= '0;
      core_rst  <= '1;
      running   <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        en_mask   <= core_en;
        cycle_cnt <= '0;
        rst_cnt   <= RCW'(RST_CYCLES - 1);
      end else begin
        if (state == RUN_RST && rst_cnt != '0) rst_cnt <= rst_cnt - RCW'(1);
        // Counter advances only while staying in RUN, so it freezes on exit or abort.
        if (state == RUN_RUN && state_nxt == RUN_RUN) cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      core_rst <= (state_nxt == RUN_RUN) ? ~en_mask : '1;
      running  <= (state_nxt == RUN_RUN);
      done     <= (state_nxt == RUN_DONE);
      timeout  <= (state_nxt == RUN_TIMEOUT);
    end
  end

  // One halt-capture slot per core.
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
    mips_run_core_slot #(
      .CNT_W(CNT_W)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .clr          (start_acc),
      .en           (en_mask[i]),
      .run          (slot_run),
      .halt         (halt[i]),
      .cycle_cnt    (cycle_cnt),
      .halted       (halted[i]),
      .finish_cycle (finish_cycle[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Purpose: randomized and directed runs of mips_run_ctrl against a run-level model.
// Latency: expected run outcomes are queued at issue and matched when done/timeout rises.
// Backpressure: n/a.
module tb_mips_run_ctrl;

  localparam int NC   = 3;
  localparam int RC   = 3;
  localparam int CW   = 16;
  localparam int MAXC = 50;

  logic             clk = 1'b0;
  logic             reset, start, abort;
  logic [NC-1:0]    core_en, halt;
  logic [NC-1:0]    core_rst, halted;
  logic             running, done, timeout;
  logic [CW-1:0]    cycle_cnt;
  logic [NC*CW-1:0] finish_cycle;

  always #5 clk = ~clk;

  mips_run_ctrl #(
    .NUM_CORES (NC),
    .RST_CYCLES(RC),
    .CNT_W     (CW),
    .MAX_CYCLES(MAXC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .core_en     (core_en),
    .halt        (halt),
    .core_rst    (core_rst),
    .running     (running),
    .done        (done),
    .timeout     (timeout),
    .halted      (halted),
    .cycle_cnt   (cycle_cnt),
    .finish_cycle(finish_cycle)
  );

  typedef struct packed {
    logic             is_done;
    logic [CW-1:0]    cyc;
    logic [NC-1:0]    hlt;
    logic [NC*CW-1:0] fin;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   hc[NC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: each rising end-of-run status is compared against the oldest queued outcome.
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if ((done || timeout) && !prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_end", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("end_done", done, e.is_done);
          chk("end_timeout", timeout, !e.is_done);
          chk("end_cycle_cnt", cycle_cnt, e.cyc);
          chk("end_halted", halted, e.hlt);
          chk("end_finish_cycle", finish_cycle, e.fin);
        end
      end
      prev = done || timeout;
    end
  end

  // Run-level model: outcome follows from the first halt cycle of each enabled core.
  function automatic exp_t model(input logic [NC-1:0] mask);
    exp_t e;
    int   c;
    logic ok;
    c  = 0;
    ok = 1'b1;
    for (int i = 0; i < NC; i++)
      if (mask[i]) begin
        if (hc[i] >= MAXC) ok = 1'b0;
        else if (hc[i] > c) c = hc[i];
      end
    e         = '0;
    e.is_done = ok;
    e.cyc     = ok ? CW'(c) : CW'(MAXC - 1);
    for (int i = 0; i < NC; i++)
      if (mask[i] && hc[i] <= int'(e.cyc)) begin
        e.hlt[i]              = 1'b1;
        e.fin[i*CW +: CW]     = CW'(hc[i]);
      end
    return e;
  endfunction

  // Issue start, then step through the reset-hold phase with random (ignored) halts.
  task automatic start_and_rst(input logic [NC-1:0] mask);
    logic [NC-1:0] ones;
    ones = '1;
    @(negedge clk);
    core_en = mask;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    core_en = NC'($urandom);
    chk("start_clr_halted", halted, 0);
    chk("start_clr_cycle_cnt", cycle_cnt, 0);
    chk("start_clr_finish", finish_cycle, 0);
    for (int r = 0; r < RC; r++) begin
      chk("rst_core_rst", core_rst, ones);
      chk("rst_running", running, 0);
      chk("rst_status", {done, timeout}, 0);
      halt = NC'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_run(input logic [NC-1:0] mask);
    exp_t          e;
    int            lim, st_k;
    logic [NC-1:0] nm, hb, ones;
    ones = '1;
    nm   = ~mask;
    e    = model(mask);
    exp_q.push_back(e);
    lim  = int'(e.cyc);
    st_k = $urandom_range(0, lim);
    start_and_rst(mask);
    for (int k = 0; k <= lim; k++) begin
      chk("run_running", running, 1);
      chk("run_core_rst", core_rst, nm);
      chk("run_cycle_cnt", cycle_cnt, CW'(k));
      for (int i = 0; i < NC; i++) begin
        if (mask[i]) hb[i] = (k == hc[i]) || (k > hc[i] && $urandom_range(0, 1) == 1);
        else         hb[i] = ($urandom_range(0, 1) == 1);
      end
      halt  = hb;
      start = (k == st_k);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    halt = '0;
    chk("end_running", running, 0);
    @(posedge clk);
    #1;
    chk("end_seen", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("frozen_cycle_cnt", cycle_cnt, e.cyc);
    chk("frozen_status", {done, timeout}, {e.is_done, !e.is_done});
    chk("frozen_core_rst", core_rst, ones);
  endtask

  task automatic set_h(input int h0, input int h1, input int h2);
    hc[0] = h0;
    hc[1] = h1;
    hc[2] = h2;
  endtask

  initial begin : watchdog
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=expired required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin : driver
    logic [NC-1:0] ones;
    ones    = '1;
    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    core_en = '0;
    halt    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_core_rst", core_rst, ones);
    chk("reset_status", {running, done, timeout}, 0);
    chk("reset_halted", halted, 0);
    chk("reset_cycle_cnt", cycle_cnt, 0);
    chk("reset_finish", finish_cycle, 0);
    reset = 1'b0;

    // Directed runs.
    set_h(9, 999, 999);    do_run(3'b001);
    set_h(5, 20, 999);     do_run(3'b011);
    set_h(999, 999, 999);  do_run(3'b001);
    set_h(49, 999, 999);   do_run(3'b001);
    set_h(999, 49, 999);   do_run(3'b010);
    set_h(2, 12, 999);     do_run(3'b010);
    set_h(999, 999, 999);  do_run(3'b000);

    // Abort at RUN cycle 7 with core0 halted at 3.
    start_and_rst(3'b011);
    for (int k = 0; k <= 7; k++) begin
      halt  = (k == 3) ? 3'b001 : 3'b000;
      abort = (k == 7);
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
    halt  = '0;
    chk("abort_core_rst", core_rst, ones);
    chk("abort_status", {running, done, timeout}, 0);
    chk("abort_halted", halted, 3'b001);
    chk("abort_cycle_cnt", cycle_cnt, 7);
    chk("abort_finish", finish_cycle, 48'd3);
    set_h(4, 999, 7);      do_run(3'b101);

    // Reset together with start at RUN cycle 3.
    start_and_rst(3'b011);
    for (int k = 0; k <= 3; k++) begin
      halt  = (k == 1) ? 3'b001 : 3'b000;
      reset = (k == 3);
      start = (k == 3);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    start = 1'b0;
    halt  = '0;
    chk("rst_mid_core_rst", core_rst, ones);
    chk("rst_mid_status", {running, done, timeout}, 0);
    chk("rst_mid_halted", halted, 0);
    chk("rst_mid_cycle_cnt", cycle_cnt, 0);
    chk("rst_mid_finish", finish_cycle, 0);
    repeat (RC + 2) @(posedge clk);
    #1;
    chk("rst_mid_start_ignored", running, 0);

    // Randomized runs.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NC; i++) begin
        case ($urandom_range(0, 4))
          0:       hc[i] = 0;
          1:       hc[i] = MAXC - 1;
          2:       hc[i] = MAXC + $urandom_range(0, 5);
          default: hc[i] = $urandom_range(0, MAXC - 1);
        endcase
      end
      do_run(NC'($urandom));
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
